// File: rtl/sdu_pkg.sv
// Shared definitions for the Spectral Doppler Ultrasound rate converters
// (upsampler / downsampler): default sample width, default rate factor,
// the two-state converter FSM type and a complex-sample record.
package sdu_pkg;

  localparam int unsigned SDU_DATA_W      = 32;
  localparam int unsigned SDU_RATE_FACTOR = 7;

  typedef enum logic [0:0] {
    IDLE,
    RUN
  } sdu_state_e;

  typedef struct packed {
    logic [SDU_DATA_W-1:0] re;
    logic [SDU_DATA_W-1:0] im;
  } sdu_cplx_t;

endpackage

// File: rtl/sample_fifo2.sv
// Two-entry synchronous FIFO for packed complex samples.
// Ports:
//   clk_i    clock, rising edge
//   rst_i    synchronous active-high reset, empties the FIFO
//   push_i   write wdata_i (ignored when full unless popping the same cycle)
//   pop_i    drop the head entry (ignored when empty)
//   wdata_i  write data
//   rdata_o  head entry, valid while !empty_o
//   count_o  occupancy 0..2
//   full_o   count_o == 2
//   empty_o  count_o == 0
module sample_fifo2 #(
  parameter int unsigned Width = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o,
  output logic [1:0]       count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [Width-1:0] mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  // A full FIFO can still take a write when the head leaves on the same edge.
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: count_q gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/upsampler.sv
// Single-clock complex interpolator: each input sample (slow rate) is expanded
// into FACTOR consecutive output words, zero-stuffed or sample-and-hold.
// Ports:
//   fast_clk                 sole clock, rising edge
//   reset                    synchronous active-high reset
//   din_valid / din_ready    input handshake, transfer when both high
//   din_re_Fs / din_im_Fs    input sample
//   dout_valid               output word valid
//   dout_first               phase 0 of an expanded sample
//   dout_re_Ff / dout_im_Ff  output sample
//   underrun                 one-cycle pulse after a frame ended with no sample queued
module upsampler
  import sdu_pkg::*;
#(
  parameter int unsigned FACTOR     = SDU_RATE_FACTOR,
  parameter int unsigned DATA_W     = SDU_DATA_W,
  parameter bit          ZERO_STUFF = 1'b1
) (
  input  logic              fast_clk,
  input  logic              reset,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic [DATA_W-1:0] din_re_Fs,
  input  logic [DATA_W-1:0] din_im_Fs,
  output logic              dout_valid,
  output logic              dout_first,
  output logic [DATA_W-1:0] dout_re_Ff,
  output logic [DATA_W-1:0] dout_im_Ff,
  output logic              underrun
);

  localparam int unsigned PhaseW    = $clog2(FACTOR);
  localparam logic [PhaseW-1:0] LastPhase = PhaseW'(FACTOR - 1);

  // Input buffer
  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [1:0]          fifo_count;
  logic [2*DATA_W-1:0] fifo_rdata, next_sample;
  logic                push, avail, load, last_phase;

  // FSM / hold stage
  sdu_state_e          state_q, state_d;
  logic [PhaseW-1:0]   phase_q, phase_d;
  logic [DATA_W-1:0]   hold_re_q, hold_re_d, hold_im_q, hold_im_d;
  logic                starve_q, starve_d;

  // Output stage
  logic                dout_valid_q, dout_valid_d;
  logic                dout_first_q, dout_first_d;
  logic [DATA_W-1:0]   dout_re_q, dout_re_d, dout_im_q, dout_im_d;
  logic                underrun_q, underrun_d;

  assign din_ready  = (fifo_count < 2'd2) && !reset;
  assign push       = din_valid && din_ready;
  // A sample accepted on this edge counts as available: it bypasses the FIFO.
  assign avail      = !fifo_empty || push;
  assign last_phase = (phase_q == LastPhase);
  assign next_sample = fifo_empty ? {din_re_Fs, din_im_Fs} : fifo_rdata;

  assign fifo_pop  = load && !fifo_empty;
  assign fifo_push = push && !(load && fifo_empty) && (!fifo_full || fifo_pop);

  sample_fifo2 #(
    .Width (2 * DATA_W)
  ) u_fifo (
    .clk_i   (fast_clk),
    .rst_i   (reset),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i ({din_re_Fs, din_im_Fs}),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    hold_re_d = hold_re_q;
    hold_im_d = hold_im_q;
    starve_d  = 1'b0;
    load      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (avail) begin
          load    = 1'b1;
          state_d = RUN;
          phase_d = '0;
        end
      end
      RUN: begin
        if (!last_phase) begin
          phase_d = phase_q + PhaseW'(1);
        end else if (avail) begin
          load    = 1'b1;
          phase_d = '0;
        end else begin
          state_d  = IDLE;
          phase_d  = '0;
          starve_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase
    if (load) begin
      {hold_re_d, hold_im_d} = next_sample;
    end
  end

  // Output words are registered from the hold stage, so they trail it by one edge;
  // underrun is delayed with them so it lines up with the first idle output.
  always_comb begin
    dout_valid_d = (state_q == RUN);
    dout_first_d = (state_q == RUN) && (phase_q == '0);
    dout_re_d    = '0;
    dout_im_d    = '0;
    underrun_d   = starve_q;
    if ((state_q == RUN) && ((phase_q == '0) || !ZERO_STUFF)) begin
      dout_re_d = hold_re_q;
      dout_im_d = hold_im_q;
    end
  end

  always_ff @(posedge fast_clk) begin
    if (reset) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      hold_re_q    <= '0;
      hold_im_q    <= '0;
      starve_q     <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_first_q <= 1'b0;
      dout_re_q    <= '0;
      dout_im_q    <= '0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      hold_re_q    <= hold_re_d;
      hold_im_q    <= hold_im_d;
      starve_q     <= starve_d;
      dout_valid_q <= dout_valid_d;
      dout_first_q <= dout_first_d;
      dout_re_q    <= dout_re_d;
      dout_im_q    <= dout_im_d;
      underrun_q   <= underrun_d;
    end
  end

  assign dout_valid = dout_valid_q;
  assign dout_first = dout_first_q;
  assign dout_re_Ff = dout_re_q;
  assign dout_im_Ff = dout_im_q;
  assign underrun   = underrun_q;

endmodule
